voter_seq_sched: RTL and testbench
==================================

Name: voter_seq_sched

Overview:
- Sequential scheduler that evaluates N-input majority votes by time-multiplexing one CHUNK-bit popcount across the vote vector.
- Replaces the 1001-input combinational voter where area or timing forbids a full-width adder tree.
- Accepts vectors over a valid/ready input, accumulates the ones count chunk by chunk, optionally terminates early, and returns the vote over a valid/ready output.

Parameters:
- N, 1001, vote vector width; must be odd.
- CHUNK, 64, bits counted per cycle.
- EARLY_EXIT, 1, 1 = stop as soon as the outcome is decided; 0 = always scan all chunks.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  vote vector valid.
- in_ready  output  1  scheduler can accept a vector.
- in_data  input  N  vote vector; bit i is voter i.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_vote  output  1  majority result: 1 if ones >= THRESH.
- out_count  output  CNT_W  ones count accumulated at termination (partial when exited early).
- busy  output  1  high in ACCUM or DONE.

Behaviour:
- Derived constants: NCHUNK = ceil(N/CHUNK) (16 by default); CNT_W = clog2(N+1) (10); THRESH = (N+1)/2 (501).
- Reset: all of the following are 0 on the cycle after rst is sampled high: out_valid, out_vote, out_count, busy, count, idx, captured vector. State = IDLE. in_ready = 0 while rst is high.
- Reset mid-operation: any in-flight vector is discarded and no result is produced.
- State machine, IDLE -> ACCUM -> DONE -> IDLE:
  - IDLE: in_ready = 1. When in_valid && in_ready, register in_data, clear count and idx, go to ACCUM.
  - ACCUM: in_ready = 0. Each cycle: count_n = count + popcount(chunk[idx]) and rem_n = N - CHUNK*(idx+1), saturated at 0. The final chunk holds N - CHUNK*(NCHUNK-1) valid bits (41 by default); its upper bits are zero-padded and never counted.
  - ACCUM termination, evaluated in this priority order:
    - EARLY_EXIT and count_n >= THRESH: vote = 1.
    - EARLY_EXIT and count_n + rem_n < THRESH: vote = 0.
    - idx == NCHUNK-1: vote = (count_n >= THRESH).
    - On any termination: load out_vote and out_count = count_n, go to DONE. Otherwise idx++ and stay in ACCUM.
  - DONE: out_valid = 1, with out_vote and out_count stable. When out_ready is high, go to IDLE and drop out_valid the next cycle. Hold indefinitely under backpressure.
- Latency: input accepted at cycle 0; k chunks processed in cycles 1..k; out_valid first high at cycle k+1. Without early exit k = NCHUNK (16), so out_valid rises at cycle 17.
- Throughput: in_ready is low in DONE even when out_ready is high, so the minimum spacing between accepted vectors is k+2 cycles. A new in_valid arriving together with out_ready is accepted on the following IDLE cycle.
- in_data is sampled only on the accept cycle; later changes to it have no effect.
- No arithmetic overflow: count never exceeds N, which fits in CNT_W.

Decomposition:
- Package voter_pkg holds N, CHUNK, NCHUNK, CNT_W, THRESH, and the state enum (IDLE, ACCUM, DONE).
- Sub-module voter_popcount: combinational, CHUNK-bit input, clog2(CHUNK+1)-bit output. It is instantiated once and fed by a chunk mux selected by idx.

Test Plan:
- All ones, EARLY_EXIT=1 -> count reaches 512 after chunk 8; out_valid at cycle 9; out_vote=1; out_count=512.
- All zeros, EARLY_EXIT=1 -> exit after chunk 8 (0 + 489 < 501); out_valid at cycle 9; out_vote=0; out_count=0.
- Bits [499:0] set, EARLY_EXIT=1 -> no early decision; out_valid at cycle 17; out_vote=0; out_count=500. Bits [500:0] set with EARLY_EXIT=0 -> cycle 17; out_vote=1; out_count=501.
- Zero-padding check: only bit 1000 set, EARLY_EXIT=0 -> out_count=1, out_vote=0; no count is contributed by the padding bits.
- Backpressure: out_ready held low for 20 cycles after out_valid -> out_valid, out_vote and out_count stay stable and in_ready stays 0. Raise out_ready with in_valid high -> out_valid drops next cycle and the new vector is accepted that same cycle (IDLE).
- Reset mid-ACCUM: assert rst at cycle 5 of a vector -> next cycle state=IDLE, busy=0, out_valid=0, out_count=0. No stale result appears, and the next vector yields a correct result.

Source files
------------

// File: rtl/voter_pkg.sv
// Shared constants and state encoding for the chunked majority voter.
// Every block that needs the vector geometry takes it from here.
package voter_pkg;

  localparam int N      = 1001;
  localparam int CHUNK  = 64;
  localparam int NCHUNK = (N + CHUNK - 1) / CHUNK;
  localparam int CNT_W  = $clog2(N + 1);
  localparam int THRESH = (N + 1) / 2;
  localparam int PC_W   = $clog2(CHUNK + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/voter_popcount.sv
// Combinational ones counter for one chunk of the vote vector.
module voter_popcount #(
  parameter int W  = 64,
  parameter int OW = $clog2(W + 1)
) (
  input  logic [W-1:0]  bits,
  output logic [OW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + OW'(bits[i]);
    end
  end

endmodule

// File: rtl/voter_seq_sched.sv
// Majority voter that walks the vote vector one chunk per cycle through a
// single popcount, optionally stopping once the outcome can no longer change.
module voter_seq_sched
  import voter_pkg::*;
#(
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_vote,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);

  localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int PAD_W = NCHUNK * CHUNK;
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

  state_t             state_reg;
  logic [N-1:0]       data_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic               out_valid_reg;
  logic               out_vote_reg;
  logic [CNT_W-1:0]   out_count_reg;
  logic               busy_reg;

  // Zero-extending the captured vector makes the last chunk's padding count as 0.
  logic [PAD_W-1:0]   padded;
  logic [CHUNK-1:0]   chunks [NCHUNK];
  logic [CHUNK-1:0]   chunk_sel;
  logic [PC_W-1:0]    chunk_cnt;

  assign padded = PAD_W'(data_reg);

  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
      assign chunks[gi] = padded[gi*CHUNK +: CHUNK];
    end
  endgenerate

  assign chunk_sel = chunks[idx_reg];

  voter_popcount #(
    .W  (CHUNK),
    .OW (PC_W)
  ) u_popcount (
    .bits  (chunk_sel),
    .count (chunk_cnt)
  );

  logic [CNT_W-1:0] count_next;
  logic [31:0]      consumed_next;
  logic [31:0]      rem_next;
  logic [31:0]      reach_next;
  logic             decide_one;
  logic             decide_zero;
  logic             last_chunk;
  logic             finish_now;
  logic             vote_now;

  always_comb begin
    count_next    = count_reg + CNT_W'(chunk_cnt);
    consumed_next = 32'(CHUNK) * (32'(idx_reg) + 32'd1);
    rem_next      = (consumed_next >= 32'(N)) ? 32'd0 : (32'(N) - consumed_next);
    // Best case still reachable: every unseen voter says 1.
    reach_next    = 32'(count_next) + rem_next;
    decide_one    = (EARLY_EXIT != 0) && (count_next >= THRESH_C);
    decide_zero   = (EARLY_EXIT != 0) && (reach_next < 32'(THRESH));
    last_chunk    = (idx_reg == IDX_W'(NCHUNK - 1));
    finish_now    = decide_one || decide_zero || last_chunk;
    if (decide_one) begin
      vote_now = 1'b1;
    end else if (decide_zero) begin
      vote_now = 1'b0;
    end else begin
      vote_now = (count_next >= THRESH_C);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      data_reg      <= '0;
      count_reg     <= '0;
      idx_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_vote_reg  <= 1'b0;
      out_count_reg <= '0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            data_reg  <= in_data;
            count_reg <= '0;
            idx_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= ACCUM;
          end
        end
        ACCUM: begin
          count_reg <= count_next;
          if (finish_now) begin
            out_vote_reg  <= vote_now;
            out_count_reg <= count_next;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            idx_reg <= idx_reg + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Held low during reset even though the state register already reads IDLE.
  assign in_ready  = (state_reg == IDLE) && !rst;
  assign out_valid = out_valid_reg;
  assign out_vote  = out_vote_reg;
  assign out_count = out_count_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_voter_seq_sched.sv
// Randomized and directed bench for voter_seq_sched; instance 0 uses early
// exit, instance 1 always scans every chunk.
module tb_voter_seq_sched;

  localparam int N      = 1001;
  localparam int CHUNK  = 64;
  localparam int NCHUNK = 16;
  localparam int THRESH = 501;
  localparam int CNT_W  = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             in_valid  [2];
  logic             in_ready  [2];
  logic [N-1:0]     in_data   [2];
  logic             out_valid [2];
  logic             out_ready [2];
  logic             out_vote  [2];
  logic [CNT_W-1:0] out_count [2];
  logic             busy      [2];

  voter_seq_sched #(.EARLY_EXIT(1)) dut_ee (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .in_data   (in_data[0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .out_vote  (out_vote[0]),
    .out_count (out_count[0]),
    .busy      (busy[0])
  );

  voter_seq_sched #(.EARLY_EXIT(0)) dut_full (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .in_data   (in_data[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .out_vote  (out_vote[1]),
    .out_count (out_count[1]),
    .busy      (busy[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: count chunk by chunk, decide from counted ones vs. ones still possible.
  function automatic void ref_vote(input logic [N-1:0] v, input bit ee,
                                   output int cnt, output bit vote, output int k);
    int seen;
    cnt  = 0;
    seen = 0;
    k    = NCHUNK;
    vote = 1'b0;
    for (int c = 0; c < NCHUNK; c++) begin
      for (int b = 0; b < CHUNK; b++) begin
        if (c * CHUNK + b < N) begin
          cnt  += int'(v[c*CHUNK+b]);
          seen += 1;
        end
      end
      k = c + 1;
      if (ee && cnt >= THRESH) begin
        vote = 1'b1;
        return;
      end
      if (ee && cnt + (N - seen) < THRESH) begin
        vote = 1'b0;
        return;
      end
    end
    vote = (cnt >= THRESH);
  endfunction

  function automatic logic [N-1:0] rand_vec(input int pct);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = ($urandom_range(99) < pct);
    return v;
  endfunction

  // Send one vector on instance d, check latency/result, hold backpressure for
  // 'hold' cycles, then release. With chain set, the next vector is presented
  // together with out_ready.
  task automatic run_vec(input int d, input logic [N-1:0] v, input int hold,
                         input bit chain, input logic [N-1:0] v_next, input string tag);
    int  exp_cnt, exp_k, cyc, waited;
    bit  exp_vote;
    logic [CNT_W-1:0] held_count;
    logic held_vote;
    ref_vote(v, (d == 0), exp_cnt, exp_vote, exp_k);
    in_data[d]  = v;
    in_valid[d] = 1'b1;
    waited = 0;
    while (!in_ready[d] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, ".in_ready_idle"}, in_ready[d], 1);
    @(posedge clk);
    @(negedge clk);
    in_valid[d] = 1'b0;
    in_data[d]  = rand_vec(50);
    cyc = 1;
    chk({tag, ".busy_accum"}, busy[d], 1);
    while (!out_valid[d] && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".latency"}, cyc, exp_k + 1);
    chk({tag, ".vote"}, out_vote[d], exp_vote);
    chk({tag, ".count"}, out_count[d], exp_cnt);
    chk({tag, ".in_ready_done"}, in_ready[d], 0);
    $display("txn %s inst=%0d cycle=%0d vote=%0d count=%0d exp_vote=%0d exp_count=%0d",
             tag, d, cyc, out_vote[d], out_count[d], exp_vote, exp_cnt);
    held_count = out_count[d];
    held_vote  = out_vote[d];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, out_valid[d], 1);
      chk({tag, ".hold_vote"}, out_vote[d], held_vote);
      chk({tag, ".hold_count"}, out_count[d], held_count);
      chk({tag, ".hold_in_ready"}, in_ready[d], 0);
    end
    out_ready[d] = 1'b1;
    if (chain) begin
      in_data[d]  = v_next;
      in_valid[d] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    out_ready[d] = 1'b0;
    chk({tag, ".valid_drop"}, out_valid[d], 0);
    chk({tag, ".busy_drop"}, busy[d], 0);
    if (chain) chk({tag, ".in_ready_after"}, in_ready[d], 1);
  endtask

  logic [N-1:0] v_a, v_b, v_zero;

  initial begin
    bit stale;
    rst = 1'b1;
    v_zero = '0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      in_data[d]   = '0;
      out_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset.in_ready", in_ready[d], 0);
      chk("reset.out_valid", out_valid[d], 0);
      chk("reset.out_vote", out_vote[d], 0);
      chk("reset.out_count", out_count[d], 0);
      chk("reset.busy", busy[d], 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    v_a = '1;
    run_vec(0, v_a, 0, 1'b0, v_zero, "all_ones_ee");
    run_vec(0, v_zero, 0, 1'b0, v_zero, "all_zeros_ee");
    v_a = '0;
    for (int i = 0; i < 500; i++) v_a[i] = 1'b1;
    run_vec(0, v_a, 0, 1'b0, v_zero, "ones500_ee");
    v_a[500] = 1'b1;
    run_vec(1, v_a, 0, 1'b0, v_zero, "ones501_full");
    v_a = '0;
    v_a[N-1] = 1'b1;
    run_vec(1, v_a, 0, 1'b0, v_zero, "bit1000_full");

    // Backpressure with the next vector waiting alongside out_ready.
    v_a = rand_vec(50);
    v_b = rand_vec(55);
    run_vec(0, v_a, 20, 1'b1, v_b, "bp_first");
    run_vec(0, v_b, 0, 1'b0, v_zero, "bp_second");

    // Load a nonzero out_count, then reset partway through the next vector.
    v_a = '1;
    run_vec(0, v_a, 0, 1'b0, v_zero, "pre_reset");
    in_data[0]  = v_a;
    in_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst.busy", busy[0], 0);
    chk("midrst.out_valid", out_valid[0], 0);
    chk("midrst.out_count", out_count[0], 0);
    chk("midrst.in_ready", in_ready[0], 0);
    rst = 1'b0;
    out_ready[0] = 1'b1;
    stale = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (out_valid[0]) stale = 1'b1;
    end
    out_ready[0] = 1'b0;
    chk("midrst.no_stale", stale, 0);
    v_a = rand_vec(48);
    run_vec(0, v_a, 1, 1'b0, v_zero, "post_reset");

    // Randomized vectors, densities clustered around the threshold.
    for (int t = 0; t < 30; t++) begin
      int pct;
      case ($urandom_range(3))
        0: pct = $urandom_range(100);
        1: pct = 45 + $urandom_range(10);
        2: pct = 49 + $urandom_range(2);
        default: pct = ($urandom_range(1) == 0) ? 0 : 100;
      endcase
      v_a = rand_vec(pct);
      run_vec(t % 2, v_a, $urandom_range(3), 1'b0, v_zero, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
